// File: rtl/imm_gen_pkg.sv
// Shared constants for the decode-stage immediate generator: instruction
// field widths and positions, plus the opcode values that carry (or do not
// carry) an immediate.
package imm_gen_pkg;

    localparam int INSTR_WIDTH  = 16;
    localparam int OPCODE_WIDTH = 6;
    localparam int IMM_WIDTH    = 10;
    localparam int DATA_WIDTH   = 16;

    // Field positions inside the instruction word
    localparam int OPC_LSB = 0;
    localparam int IMM_LSB = 6;
    localparam int IMM_MSB = 15;

    // Opcodes, for documentation and stimulus; the generator itself is opcode-agnostic
    localparam logic [OPCODE_WIDTH-1:0] OPC_PUSH = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] OPC_ADD  = 6'h07;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JNZ  = 6'h13;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JUMP = 6'h0E;

endpackage : imm_gen_pkg

// File: rtl/imm_generator_sign_extender.sv
// sign_extender: purely combinational two's-complement widening from
// IN_WIDTH to OUT_WIDTH by replicating the input MSB.
module sign_extender #(
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]  i_data,
    output logic [OUT_WIDTH-1:0] o_data
);

    generate
        if (OUT_WIDTH < IN_WIDTH) begin : g_bad_width
            $error("sign_extender: OUT_WIDTH must be >= IN_WIDTH");
        end else if (OUT_WIDTH == IN_WIDTH) begin : g_pass
            // Nothing to extend; a zero-count replication would be illegal
            assign o_data = i_data;
        end else begin : g_extend
            assign o_data = {{(OUT_WIDTH-IN_WIDTH){i_data[IN_WIDTH-1]}}, i_data};
        end
    endgenerate

endmodule : sign_extender

// File: rtl/imm_generator.sv
// imm_generator: splits a stack-CPU instruction into opcode and immediate,
// sign-extends the immediate to the datapath width and registers it once.
// Optional build macro IMMGEN_HOLD_EN adds an in_enable stall input; when it
// is undefined the register loads every cycle.
module imm_generator
    import imm_gen_pkg::*;
#(
    parameter int P_INSTR_WIDTH  = INSTR_WIDTH,
    parameter int P_OPCODE_WIDTH = OPCODE_WIDTH,
    parameter int P_IMM_WIDTH    = IMM_WIDTH,
    parameter int P_DATA_WIDTH   = DATA_WIDTH
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
`ifdef IMMGEN_HOLD_EN
    input  logic                     in_enable,
`endif
    input  logic [P_INSTR_WIDTH-1:0] in_instruction,
    output logic [P_DATA_WIDTH-1:0]  ot_immediate_output
);

    // The opcode and immediate fields must tile the instruction word exactly
    generate
        if (P_INSTR_WIDTH != P_OPCODE_WIDTH + P_IMM_WIDTH) begin : g_bad_split
            $error("imm_generator: INSTR_WIDTH must equal OPCODE_WIDTH + IMM_WIDTH");
        end
    endgenerate

    logic [P_OPCODE_WIDTH-1:0] w_unused_opcode;
    logic [P_IMM_WIDTH-1:0]    w_imm;
    logic [P_DATA_WIDTH-1:0]   w_imm_ext;
    logic [P_DATA_WIDTH-1:0]   r_imm;

    // Opcode is split off only for readability; downstream consumers decide
    // whether the immediate means anything for the current instruction.
    assign w_unused_opcode = in_instruction[P_OPCODE_WIDTH-1:0];
    assign w_imm           = in_instruction[P_INSTR_WIDTH-1:P_OPCODE_WIDTH];

    sign_extender #(
        .IN_WIDTH  (P_IMM_WIDTH),
        .OUT_WIDTH (P_DATA_WIDTH)
    ) u_sign_extender (
        .i_data (w_imm),
        .o_data (w_imm_ext)
    );

    // Output register: async clear, otherwise capture the extended immediate
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_imm <= {P_DATA_WIDTH{1'b0}};
        end else begin
`ifdef IMMGEN_HOLD_EN
            if (in_enable) begin
                r_imm <= w_imm_ext;
            end else begin
                r_imm <= r_imm;
            end
`else
            r_imm <= w_imm_ext;
`endif
        end
    end

    assign ot_immediate_output = r_imm;

endmodule : imm_generator

// File: tb/tb_imm_generator.sv
// Directed self-checking bench for imm_generator. Inputs change on the
// falling edge; outputs are checked on the following falling edge, i.e. one
// rising edge later.
module tb_imm_generator;
    import imm_gen_pkg::*;

    logic        in_clk;
    logic        in_rst;
`ifdef IMMGEN_HOLD_EN
    logic        in_enable;
`endif
    logic [15:0] in_instruction;
    logic [15:0] ot_immediate_output;

    int total;
    int bad;

    imm_generator dut (
        .in_clk              (in_clk),
        .in_rst              (in_rst),
`ifdef IMMGEN_HOLD_EN
        .in_enable           (in_enable),
`endif
        .in_instruction      (in_instruction),
        .ot_immediate_output (ot_immediate_output)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic test_reset();
        in_rst         = 1'b0;
        in_instruction = 16'hFD0E;
        for (int i = 0; i < 3; i++) begin
            @(negedge in_clk);
            total++;
            if (ot_immediate_output !== 16'h0000) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: got %h expected 0000", i, ot_immediate_output);
            end
        end
        in_rst = 1'b1;
    endtask

    task automatic test_positive();
        in_instruction = 16'h0082;          // push, imm 2
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'h0002) begin
            bad++;
            $display("FAIL push_imm2: got %h expected 0002", ot_immediate_output);
        end
        in_instruction = 16'h0213;          // jnz, imm 8
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'h0008) begin
            bad++;
            $display("FAIL jnz_imm8: got %h expected 0008", ot_immediate_output);
        end
    endtask

    task automatic test_opcode_ignored();
        in_instruction = 16'h0007;          // add, no immediate
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'h0000) begin
            bad++;
            $display("FAIL add_zero: got %h expected 0000", ot_immediate_output);
        end
        in_instruction = 16'hFFC7;
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'hFFFF) begin
            bad++;
            $display("FAIL add_ones: got %h expected FFFF", ot_immediate_output);
        end
        in_instruction = 16'hFFC0;          // same imm, opcode 0
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'hFFFF) begin
            bad++;
            $display("FAIL opc0_ones: got %h expected FFFF", ot_immediate_output);
        end
    endtask

    task automatic test_negative();
        in_instruction = 16'hFD0E;          // jump, imm 0x3F4 = -12
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'hFFF4) begin
            bad++;
            $display("FAIL jump_neg12: got %h expected FFF4", ot_immediate_output);
        end
    endtask

    task automatic test_boundary();
        logic [15:0] instr_tab [4] = '{16'h7FC0, 16'h8000, 16'h003F, 16'h5540};
        logic [15:0] exp_tab   [4] = '{16'h01FF, 16'hFE00, 16'h0000, 16'h0155};
        for (int i = 0; i < 4; i++) begin
            in_instruction = instr_tab[i];
            @(negedge in_clk);
            total++;
            if (ot_immediate_output !== exp_tab[i]) begin
                bad++;
                $display("FAIL boundary[%0d] instr %h: got %h expected %h",
                         i, instr_tab[i], ot_immediate_output, exp_tab[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Output must track the input exactly one edge later, every cycle
        logic [15:0] instr_tab [5] = '{16'h0082, 16'h8000, 16'h7FC0, 16'hFD0E, 16'h0213};
        logic [15:0] exp_tab   [5] = '{16'h0002, 16'hFE00, 16'h01FF, 16'hFFF4, 16'h0008};
        for (int i = 0; i < 5; i++) begin
            in_instruction = instr_tab[i];
            @(negedge in_clk);
            total++;
            if (ot_immediate_output !== exp_tab[i]) begin
                bad++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, ot_immediate_output, exp_tab[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        in_instruction = 16'hFD0E;
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'hFFF4) begin
            bad++;
            $display("FAIL pre_reset: got %h expected FFF4", ot_immediate_output);
        end
        #1;
        in_rst = 1'b0;                      // between edges
        #1;
        total++;
        if (ot_immediate_output !== 16'h0000) begin
            bad++;
            $display("FAIL async_clear: got %h expected 0000", ot_immediate_output);
        end
        @(posedge in_clk);
        #1;
        total++;
        if (ot_immediate_output !== 16'h0000) begin
            bad++;
            $display("FAIL reset_over_edge: got %h expected 0000", ot_immediate_output);
        end
        @(negedge in_clk);
        in_rst         = 1'b1;
        in_instruction = 16'h0082;
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'h0002) begin
            bad++;
            $display("FAIL first_after_reset: got %h expected 0002", ot_immediate_output);
        end
    endtask

`ifdef IMMGEN_HOLD_EN
    task automatic test_hold();
        in_enable      = 1'b1;
        in_instruction = 16'h0082;
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'h0002) begin
            bad++;
            $display("FAIL hold_load: got %h expected 0002", ot_immediate_output);
        end
        in_enable      = 1'b0;
        in_instruction = 16'hFD0E;
        @(negedge in_clk);
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'h0002) begin
            bad++;
            $display("FAIL hold_stall: got %h expected 0002", ot_immediate_output);
        end
        in_enable = 1'b1;
        @(negedge in_clk);
        total++;
        if (ot_immediate_output !== 16'hFFF4) begin
            bad++;
            $display("FAIL hold_resume: got %h expected FFF4", ot_immediate_output);
        end
        in_enable = 1'b0;
        in_rst    = 1'b0;
        #1;
        total++;
        if (ot_immediate_output !== 16'h0000) begin
            bad++;
            $display("FAIL hold_reset: got %h expected 0000", ot_immediate_output);
        end
        @(negedge in_clk);
        in_rst    = 1'b1;
        in_enable = 1'b1;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
`ifdef IMMGEN_HOLD_EN
        in_enable = 1'b1;
`endif
        in_rst         = 1'b0;
        in_instruction = 16'h0000;
        @(negedge in_clk);
        test_reset();
        test_positive();
        test_opcode_ignored();
        test_negative();
        test_boundary();
        test_back_to_back();
        test_async_reset();
`ifdef IMMGEN_HOLD_EN
        test_hold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_imm_generator
